// File: rtl/ou_ctrl.sv
// Control sequencer for the ones'-complement adder path: load, add, end-around carry,
// negative-zero fix and overflow report, driving the datapath with one-cycle strobes.
module ou_ctrl #(
  parameter int OP_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic            cout,
  input  logic            ks4,
  input  logic            ovf,
  output logic            y_lda,
  output logic            y_clr_a,
  output logic            y_ldb,
  output logic            y_clr_b,
  output logic            y_invb,
  output logic            y_sum,
  output logic            y_inc,
  output logic            y_clr_rr,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_NEG  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_PASS = OP_W'(3);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, ADD, CARRY, CHECK, FIX, DONE
  } state_t;

  typedef struct packed {
    logic lda;
    logic clr_a;
    logic ldb;
    logic clr_b;
    logic invb;
    logic sum;
    logic inc;
    logic clr_rr;
    logic busy;
    logic done;
  } outs_t;

  state_t          state, state_n;
  logic [OP_W-1:0] op_r, op_n;
  outs_t           outs;

  function automatic outs_t decode(input state_t s, input logic [OP_W-1:0] o);
    outs_t d;
    d = '0;
    case (s)
      LOAD_A: begin
        d.busy = 1'b1;
        if (o == OP_NEG) d.clr_a = 1'b1;
        else             d.lda   = 1'b1;
      end
      LOAD_B: begin
        d.busy = 1'b1;
        if (o == OP_PASS) d.clr_b = 1'b1;
        else              d.ldb   = 1'b1;
        d.invb = (o == OP_SUB) || (o == OP_NEG);
      end
      ADD: begin
        d.busy = 1'b1;
        d.sum  = 1'b1;
        d.invb = (o == OP_SUB) || (o == OP_NEG);
      end
      CARRY: begin
        d.busy = 1'b1;
        d.inc  = 1'b1;
      end
      CHECK: d.busy = 1'b1;
      FIX: begin
        d.busy   = 1'b1;
        d.clr_rr = 1'b1;
      end
      DONE:    d.done = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

  always_comb begin
    state_n = state;
    op_n    = op_r;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD_A;
          op_n    = op;
        end
      end
      LOAD_A:  state_n = LOAD_B;
      LOAD_B:  state_n = ADD;
      ADD:     state_n = cout ? CARRY : CHECK;
      CARRY:   state_n = CHECK;
      CHECK:   state_n = ks4 ? FIX : DONE;
      FIX:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they equal a decode of the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_r  <= '0;
      err   <= 1'b0;
      outs  <= '0;
    end else begin
      state <= state_n;
      op_r  <= op_n;
      outs  <= decode(state_n, op_n);
      if (state == IDLE && start) err <= 1'b0;
      else if (state == CHECK)    err <= ovf;
    end
  end

  assign {y_lda, y_clr_a, y_ldb, y_clr_b, y_invb, y_sum, y_inc, y_clr_rr, busy, done} = outs;

endmodule

// File: tb/tb_ou_ctrl.sv
// Bench for ou_ctrl with a 5-bit ones'-complement datapath model and an arithmetic
// reference for result, overflow and cycle count.
module tb_ou_ctrl;

  localparam logic [1:0] ADD_OP = 2'b00, SUB_OP = 2'b01, NEG_OP = 2'b10, PASS_OP = 2'b11;

  logic clk = 1'b0;
  logic rst_n, start;
  logic [1:0] op;
  logic cout, ks4, ovf;
  logic y_lda, y_clr_a, y_ldb, y_clr_b, y_invb, y_sum, y_inc, y_clr_rr, busy, done, err;

  always #5 clk = ~clk;

  ou_ctrl #(.OP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .cout(cout), .ks4(ks4), .ovf(ovf),
    .y_lda(y_lda), .y_clr_a(y_clr_a), .y_ldb(y_ldb), .y_clr_b(y_clr_b),
    .y_invb(y_invb), .y_sum(y_sum), .y_inc(y_inc), .y_clr_rr(y_clr_rr),
    .busy(busy), .done(done), .err(err)
  );

  // Datapath: registers A, B, RR and the overflow flag, driven by the strobes.
  logic [4:0] bus_a, bus_b, ma, mb, mrr, bx, fin;
  logic [5:0] s6;
  logic       mov;
  assign bx   = y_invb ? ~mb : mb;
  assign s6   = {1'b0, ma} + {1'b0, bx};
  assign fin  = s6[4:0] + {4'b0, s6[5]};
  assign cout = s6[5];
  assign ks4  = (mrr == 5'h1f);
  assign ovf  = mov;

  always @(posedge clk) begin
    if (y_lda)   ma <= bus_a;
    if (y_clr_a) ma <= '0;
    if (y_ldb)   mb <= bus_b;
    if (y_clr_b) mb <= '0;
    if (y_sum) begin
      mrr <= s6[4:0];
      mov <= (ma[4] == bx[4]) && (fin[4] != ma[4]);
    end
    if (y_inc)    mrr <= mrr + 5'd1;
    if (y_clr_rr) mrr <= '0;
  end

  logic [9:0] obs;
  assign obs = {y_lda, y_clr_a, y_ldb, y_clr_b, y_invb, y_sum, y_inc, y_clr_rr, busy, done};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Structural rules checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("one_strobe", ($countones({y_lda, y_clr_a, y_ldb, y_clr_b, y_sum, y_inc, y_clr_rr}) <= 1), 1);
      chk("invb_alone", (!y_invb || y_ldb || y_sum), 1);
      chk("done_busy", (done && busy), 0);
    end
  end

  typedef logic [9:0] vq_t[$];

  // Expected per-cycle output words for one operation, from LOAD_A through DONE.
  task automatic build(input logic [1:0] o, input logic c, input logic z, output vq_t q);
    logic [9:0] v;
    q = {};
    q.push_back((o == NEG_OP) ? 10'b0100000010 : 10'b1000000010);
    v = (o == PASS_OP) ? 10'b0001000010 : 10'b0010000010;
    if (o == SUB_OP || o == NEG_OP) v = v | 10'b0000100000;
    q.push_back(v);
    v = 10'b0000010010;
    if (o == SUB_OP || o == NEG_OP) v = v | 10'b0000100000;
    q.push_back(v);
    if (c) q.push_back(10'b0000001010);
    q.push_back(10'b0000000010);
    if (z) q.push_back(10'b0000000110);
    q.push_back(10'b0000000001);
  endtask

  function automatic void ref_model(input logic [1:0] o, input logic [4:0] a, input logic [4:0] b,
                                    output logic [4:0] rr, output logic e, output logic c,
                                    output logic z);
    int ap, bp, bxv, s, r, va, vb;
    ap  = (o == NEG_OP) ? 0 : int'(a);
    bp  = (o == PASS_OP) ? 0 : int'(b);
    bxv = (o == SUB_OP || o == NEG_OP) ? 31 - bp : bp;
    s   = ap + bxv;
    c   = (s >= 32);
    r   = (s % 32 + int'(c)) % 32;
    z   = (r == 31);
    rr  = z ? 5'd0 : 5'(r);
    va  = (ap >= 16) ? ap - 31 : ap;
    vb  = (bxv >= 16) ? bxv - 31 : bxv;
    e   = (va + vb > 15) || (va + vb < -15);
  endfunction

  // Runs one operation from IDLE; poke raises start and changes op while busy.
  task automatic run_op(input logic [1:0] o, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] e_rr, input logic e_err, input logic c,
                        input logic z, input bit poke);
    vq_t exp_q;
    vq_t got_q;
    build(o, c, z, exp_q);
    @(negedge clk);
    op = o; bus_a = a; bus_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      got_q.push_back(obs);
      if (i == 0) chk("err_clear_on_accept", err, 0);
      if (poke && i == 1) begin start = 1'b1; op = ~o; end
      if (poke && i == 2) start = 1'b0;
      if (done) break;
    end
    chk("latency", got_q.size(), 5 + int'(c) + int'(z));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("trace[%0d]", i), (i < got_q.size()) ? got_q[i] : 10'h3ff, exp_q[i]);
    chk("rr", mrr, e_rr);
    chk("err", err, e_err);
    @(negedge clk);
    chk("idle_after_done", obs, 0);
    chk("err_hold", err, e_err);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [4:0] a, b, rr;
    logic       err, c, z;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [4:0] r_rr, ra, rb;
    logic       r_e, r_c, r_z;
    logic [1:0] ro;
    vq_t        t1;
    vq_t        b2b;

    tbl[0] = '{ADD_OP,  5'b00011, 5'b00010, 5'b00101, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{SUB_OP,  5'b00101, 5'b00011, 5'b00010, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{SUB_OP,  5'b00011, 5'b00011, 5'b00000, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{PASS_OP, 5'b00001, 5'b00111, 5'b00001, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{NEG_OP,  5'b00101, 5'b00110, 5'b11001, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{ADD_OP,  5'b11111, 5'b11111, 5'b00000, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{NEG_OP,  5'b01010, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{SUB_OP,  5'b10000, 5'b00001, 5'b01111, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{ADD_OP,  5'b01111, 5'b00001, 5'b10000, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; bus_a = '0; bus_b = '0;
    #3;
    chk("reset_outputs", obs, 0);
    chk("reset_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k])
      run_op(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].rr, tbl[k].err, tbl[k].c, tbl[k].z, 1'b0);

    repeat (2) begin
      @(negedge clk);
      chk("err_hold_idle", err, 1);
    end
    run_op(PASS_OP, 5'b00001, 5'b00011, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort an ADD by reset while err is set from the previous operation.
    run_op(SUB_OP, 5'b10000, 5'b00001, 5'b01111, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    op = ADD_OP; bus_a = 5'b00011; bus_b = 5'b00010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("in_add", obs, 10'b0000010010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", obs, 0);
    chk("async_reset_err", err, 0);
    repeat (2) begin
      @(negedge clk);
      chk("held_reset_outputs", obs, 0);
    end
    rst_n = 1'b1;
    run_op(ADD_OP, 5'b00011, 5'b00010, 5'b00101, 1'b0, 1'b0, 1'b0, 1'b0);

    run_op(ADD_OP, 5'b00011, 5'b00010, 5'b00101, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("busy_start_ignored", obs, 0);

    // start held high: three ADDs with one IDLE cycle between them.
    build(ADD_OP, 1'b0, 1'b0, t1);
    b2b = {t1, 10'b0, t1, 10'b0, t1};
    @(negedge clk);
    op = ADD_OP; bus_a = 5'b00011; bus_b = 5'b00010; start = 1'b1;
    for (int i = 0; i < b2b.size(); i++) begin
      @(negedge clk);
      chk($sformatf("b2b[%0d]", i), obs, b2b[i]);
      if (i == b2b.size() - 1) start = 1'b0;
    end
    chk("b2b_rr", mrr, 5'b00101);
    @(negedge clk);
    chk("b2b_stop", obs, 0);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      ref_model(ro, ra, rb, r_rr, r_e, r_c, r_z);
      run_op(ro, ra, rb, r_rr, r_e, r_c, r_z, n[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ou_ctrl.md
# ou_ctrl

Control unit for the operational block's ones'-complement adder path. It sequences the operation: load operands, add, apply the end-around carry, correct negative zero, report overflow. It drives the operand registers, the adder and the result register RR through one-cycle control strobes. It takes back the adder carry-out, the negative-zero flag of RR and the overflow flag. It sits between the instruction sequencer (start/op/done handshake) and the datapath.

## Interface
- OP_W, 2, width of the operation code; codes: 00 ADD (A+B), 01 SUB (A−B), 10 NEG (0−B), 11 PASS (A+0)
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  operation request, sampled only in IDLE
- op  in  OP_W  operation code, captured into op_r when start is accepted
- cout  in  1  adder carry-out from the sign position, sampled in ADD
- ks4  in  1  RR negative-zero flag (RR all ones), sampled in CHECK
- ovf  in  1  datapath overflow flag, sampled in CHECK
- y_lda  out  1  load operand register A from the bus
- y_clr_a  out  1  clear register A
- y_ldb  out  1  load operand register B from the bus
- y_clr_b  out  1  clear register B
- y_invb  out  1  adder takes ~B instead of B
- y_sum  out  1  RR <= A + B(or ~B)
- y_inc  out  1  RR <= RR + 1 (end-around carry)
- y_clr_rr  out  1  RR <= 0
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  overflow of the last operation

## Operation
- States: IDLE, LOAD_A, LOAD_B, ADD, CARRY, CHECK, FIX, DONE; encoding is free.
- All y_*, busy and done are Moore outputs, decoded from the state and op_r only. err is a register.
- IDLE: no strobes, busy=0. If start=1: capture op_r<=op, clear err, go to LOAD_A.
- LOAD_A: y_clr_a=1 for NEG, otherwise y_lda=1 → LOAD_B.
- LOAD_B: y_clr_b=1 for PASS, otherwise y_ldb=1. y_invb=1 for SUB and NEG → ADD.
- ADD: y_sum=1, with y_invb as in LOAD_B. cout=1 → CARRY, else → CHECK.
- CARRY: y_inc=1 → CHECK.
- CHECK: err<=ovf. ks4=1 → FIX, else → DONE.
- FIX: y_clr_rr=1, converting −0 to +0 → DONE.
- DONE: done=1 → IDLE.
- busy=1 in LOAD_A, LOAD_B, ADD, CARRY, CHECK and FIX; 0 in IDLE and DONE.
- At most one y_* strobe is active per cycle, except y_invb, which accompanies y_ldb or y_sum.
- start outside IDLE is ignored; no queuing. op changes after acceptance have no effect.
- err holds from CHECK until the next accepted start. Overflow does not suppress FIX.

## Timing
- Reset: state=IDLE, op_r=00, err=0. All outputs are 0 immediately on rst_n low, independent of clk.
- Reset mid-operation aborts with no done pulse. The first start after rst_n deasserts is accepted normally.
- Latency, start-accepting edge to the edge ending DONE:
  - 5 cycles with no carry and no −0
  - 6 cycles with either carry or −0
  - 7 cycles with both
- done is high exactly one cycle and is never asserted with busy.
- start held high continuously produces back-to-back operations separated by exactly one IDLE cycle after DONE.
- cout is sampled on the edge leaving ADD. ks4 and ovf are sampled on the edge leaving CHECK. The datapath must present them valid combinationally in those states.

## Test plan
All scenarios use a behavioural N=4 datapath model: 5-bit ones'-complement registers, ks4 = (RR == 11111).
- ADD, A=00011, B=00010: no carry, no −0 → RR=00101, err=0, done 5 cycles after start, y_inc and y_clr_rr never pulse.
- SUB, A=00101, B=00011: sum 00101+11100 carries → CARRY pulse, RR=00010, done at 6 cycles.
- SUB, A=00011, B=00011: sum 11111, ks4=1 → FIX pulse, RR=00000, done at 6 cycles.
- ADD, A=01111, B=00001: RR=10000, ovf=1 → err=1 after CHECK, held until the next start. The next op (PASS A=00001) clears err at acceptance.
- rst_n low during ADD: all outputs 0 within the same cycle, no done, state IDLE. start one cycle after release → normal 5-cycle completion.
- start held high for 3 operations, plus a start pulse during busy: each done separated by one IDLE cycle; the mid-operation pulse is ignored and op_r keeps its captured value.
